// File: rtl/fir_mac_sequencer_pkg.sv
// fir_mac_sequencer_pkg: shared widths, saturation constant and FSM states
package fir_mac_sequencer_pkg;
  localparam int DW_DEF = 10;
  localparam int MW_DEF = 2*DW_DEF-2;
  localparam int OW_DEF = 2*DW_DEF-1;
  localparam logic [MW_DEF-1:0] SAT_DEF = '1;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
endpackage

// File: rtl/fir_sm_mac.sv
// fir_sm_mac: sign-magnitude multiply plus saturating sign-magnitude accumulate
module fir_sm_mac
  import fir_mac_sequencer_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0]   x,
  input  logic [DW-1:0]   c,
  input  logic            acc_s,
  input  logic [2*DW-3:0] acc_m,
  output logic            sum_s,
  output logic [2*DW-3:0] sum_m,
  output logic            ovf
);
  localparam int MW = 2*DW-2;
  logic [MW-1:0] pm;
  logic [MW:0] add;
  logic ps;
  logic same;
  logic ge;
  assign pm = MW'(x[DW-2:0]) * MW'(c[DW-2:0]);
  assign ps = (pm != '0) && (x[DW-1] ^ c[DW-1]);
  assign add = {1'b0, acc_m} + {1'b0, pm};
  assign same = acc_s == ps;
  assign ge = acc_m >= pm;
  assign ovf = same && add[MW];
  assign sum_m = same ? (add[MW] ? '1 : add[MW-1:0]) : (ge ? acc_m - pm : pm - acc_m);
  assign sum_s = (sum_m != '0) && (same ? acc_s : (ge ? acc_s : ps));
endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: one-tap-per-cycle sign-magnitude FIR with valid/ready handshakes
module fir_mac_sequencer
  import fir_mac_sequencer_pkg::*;
#(
  parameter int N_TAPS = 16,
  parameter int DW = DW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DW-1:0]             in_sample,
  output logic                      in_ready,
  input  logic                      coef_we,
  input  logic [$clog2(N_TAPS)-1:0] coef_addr,
  input  logic [DW-1:0]             coef_data,
  output logic                      out_valid,
  output logic [2*DW-2:0]           out_data,
  input  logic                      out_ready,
  output logic                      busy
);
  localparam int AW = $clog2(N_TAPS);
  localparam int MW = 2*DW-2;
  state_t state, state_n;
  logic [DW-1:0] xs [N_TAPS];
  logic [DW-1:0] cs [N_TAPS];
  logic [AW-1:0] k;
  logic acc_s;
  logic [MW-1:0] acc_m;
  logic sat;
  logic sum_s;
  logic [MW-1:0] sum_m;
  logic ovf;
  logic accept;
  logic last;
  assign in_ready = (state == IDLE) && !rst;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign out_data = {acc_s, acc_m};
  assign accept = in_valid && in_ready;
  assign last = k == AW'(N_TAPS-1);
  fir_sm_mac #(.DW(DW)) u_mac (
    .x(xs[k]),
    .c(cs[k]),
    .acc_s(acc_s),
    .acc_m(acc_m),
    .sum_s(sum_s),
    .sum_m(sum_m),
    .ovf(ovf)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept ? MAC : IDLE) :
              state == MAC  ? (last ? DONE : MAC) :
              (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        xs[i] <= '0;
        cs[i] <= '0;
      end
      k <= '0;
      acc_s <= 1'b0;
      acc_m <= '0;
      sat <= 1'b0;
    end else begin
      if (state == IDLE && coef_we && int'(coef_addr) < N_TAPS) cs[coef_addr] <= coef_data;
      if (accept) begin
        xs[0] <= in_sample;
        for (int i = 1; i < N_TAPS; i++) xs[i] <= xs[i-1];
        k <= '0;
        acc_s <= 1'b0;
        acc_m <= '0;
        sat <= 1'b0;
      end else if (state == MAC) begin
        k <= k + 1'b1;
        if (!sat) begin
          acc_s <= sum_s;
          acc_m <= sum_m;
          sat <= ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed vector bench for fir_mac_sequencer
module tb_fir_mac_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [9:0] in_sample;
  logic in_ready;
  logic coef_we;
  logic [3:0] coef_addr;
  logic [9:0] coef_data;
  logic out_valid;
  logic [18:0] out_data;
  logic out_ready;
  logic busy;
  logic [18:0] r;
  int total = 0;
  int passed = 0;
  typedef struct {
    logic [9:0] s;
    logic [18:0] e;
  } vec_t;
  vec_t imp [17];
  fir_mac_sequencer dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_sample(in_sample),
    .in_ready(in_ready),
    .coef_we(coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    tick;
    chk("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready_after", 32'(in_ready), 1);
  endtask
  task automatic wr(input int a, input logic [9:0] d);
    coef_we = 1'b1;
    coef_addr = 4'(a);
    coef_data = d;
    tick;
    coef_we = 1'b0;
  endtask
  task automatic wait_out;
    int n = 0;
    while (!out_valid && n < 100) begin
      tick;
      n++;
    end
    chk("out_valid_seen", 32'(out_valid), 1);
  endtask
  task automatic send(input logic [9:0] s, output logic [18:0] res);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick;
      n++;
    end
    in_valid = 1'b1;
    in_sample = s;
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      tick;
      n++;
    end
    chk("latency", 32'(n), 16);
    res = out_data;
    tick;
  endtask
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_sample = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b1;
    imp[0] = '{10'h001, 19'd1};
    for (int i = 1; i < 17; i++) imp[i] = '{10'h000, (i < 16) ? 19'(i + 1) : 19'd0};
    do_reset;
    for (int i = 0; i < 16; i++) wr(i, 10'(i + 1));
    for (int i = 0; i < 17; i++) begin
      send(imp[i].s, r);
      chk($sformatf("impulse%0d", i), 32'(r), 32'(imp[i].e));
    end
    do_reset;
    for (int i = 0; i < 16; i++) wr(i, 10'd3);
    send(10'h205, r);
    chk("signmix_neg", 32'(r), 32'h4000F);
    send(10'h005, r);
    chk("signmix_zero", 32'(r), 0);
    do_reset;
    for (int i = 0; i < 16; i++) wr(i, 10'h1FF);
    for (int i = 0; i < 16; i++) begin
      send(10'h1FF, r);
      chk($sformatf("sat%0d", i), 32'(r), (i == 0) ? 32'h3FC01 : 32'h3FFFF);
    end
    do_reset;
    wr(0, 10'd9);
    wr(1, 10'd2);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_sample = 10'd4;
    tick;
    in_valid = 1'b0;
    wait_out;
    in_valid = 1'b1;
    in_sample = 10'd7;
    for (int i = 0; i < 10; i++) begin
      chk("bp_data", 32'(out_data), 36);
      chk("bp_in_ready", 32'(in_ready), 0);
      tick;
    end
    in_valid = 1'b0;
    chk("bp_release_data", 32'(out_data), 36);
    out_ready = 1'b1;
    tick;
    chk("bp_out_valid_low", 32'(out_valid), 0);
    send(10'd1, r);
    chk("bp_next", 32'(r), 17);
    in_valid = 1'b1;
    in_sample = 10'd5;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 17; i++) begin
      send(imp[i].s, r);
      chk($sformatf("cleared%0d", i), 32'(r), 0);
    end
    do_reset;
    wr(0, 10'd2);
    in_valid = 1'b1;
    in_sample = 10'd7;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick;
    coef_we = 1'b1;
    coef_addr = 4'd0;
    coef_data = 10'd100;
    tick;
    coef_we = 1'b0;
    wait_out;
    chk("mac_we_ignored", 32'(out_data), 14);
    tick;
    send(10'd1, r);
    chk("mac_we_after", 32'(r), 2);
    coef_we = 1'b1;
    coef_addr = 4'd0;
    coef_data = 10'd4;
    in_valid = 1'b1;
    in_sample = 10'd3;
    tick;
    coef_we = 1'b0;
    in_valid = 1'b0;
    wait_out;
    chk("same_cycle_we", 32'(out_data), 12);
    tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 Parameter N_TAPS, default 16, meaning: number of filter taps (range 2..64).
REQ-002 Parameter DW, default 10, meaning: sign-magnitude sample/coefficient width (bit DW-1 = sign).
REQ-003 clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  new sample offered.
REQ-006 in_sample  input  DW  sign-magnitude sample.
REQ-007 in_ready  output  1  sequencer can accept a sample.
REQ-008 coef_we  input  1  coefficient write strobe.
REQ-009 coef_addr  input  log2(N_TAPS)  coefficient index.
REQ-010 coef_data  input  DW  sign-magnitude coefficient.
REQ-011 out_valid  output  1  filtered result available.
REQ-012 out_data  output  2*DW-1  sign-magnitude result (bit 2*DW-2 = sign, 2*DW-2 magnitude bits).
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 busy  output  1  high in MAC and DONE states.

Function
REQ-015 FSM states IDLE, MAC, DONE; IDLE->MAC on in_valid&&in_ready; MAC->DONE after tap N_TAPS-1 processed; DONE->IDLE on out_valid&&out_ready.
REQ-016 in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 On accept: delay line shifts (x[k] <= x[k-1], x[0] <= in_sample), accumulator clears to +0, tap index k clears to 0.
REQ-018 MAC: one tap per cycle, acc <= acc + x[k]*c[k], k increments; exactly N_TAPS MAC cycles.
REQ-019 Product: magnitude = |x|*|c| (2*DW-2 bits, never overflows), sign = sign(x) XOR sign(c).
REQ-020 Accumulate in sign-magnitude: equal signs add magnitudes; unequal signs subtract smaller from larger, sign of larger.
REQ-021 Magnitude overflow saturates to all-ones (2^(2*DW-2)-1), sign kept; saturation sticky for remainder of that output.
REQ-022 Zero magnitude (product or accumulator) always carries sign 0; no negative zero ever emitted.
REQ-023 Latency: out_valid rises N_TAPS+1 cycles after accept cycle; throughput one sample per N_TAPS+2 cycles with out_ready held high.
REQ-024 out_data held stable while out_valid && !out_ready; no new sample accepted during backpressure.
REQ-025 coef_we honoured only in IDLE; writes in MAC/DONE ignored (coefficients unchanged).
REQ-026 coef_we and sample accept in same IDLE cycle: coefficient write takes effect before the MAC pass using it.
REQ-027 Out-of-range coef_addr (>= N_TAPS) ignored.

Reset
REQ-028 rst: FSM->IDLE, in_ready=0 during rst cycle then 1, out_valid=0, out_data=0, busy=0.
REQ-029 rst clears delay line and all coefficients to +0, accumulator and tap index to 0.
REQ-030 rst mid-MAC or in DONE aborts pass; no out_valid for the aborted sample.

Structure
REQ-031 Shared package holds DW default, product/accumulator widths, FSM state enum, saturation constant.
REQ-032 One sub-module: fir_sm_mac (combinational sign-magnitude multiply + saturating add, REQ-019..022).
REQ-033 Delay line and coefficient bank are flop arrays inside fir_mac_sequencer; no memory macros.

Verification
REQ-034 Impulse: c[k]=k+1 (positive), in 0x001 then N_TAPS zeros -> outputs 1,2,...,16 in order, sign 0.
REQ-035 Sign mix: all c=+3, samples -5 then +5 -> first out magnitude 15 sign 1; second out 0 with sign 0.
REQ-036 Saturation: all c=+511, all samples +511 for 16 inputs -> out_data magnitude 0x3FFFF, sign 0, no wrap.
REQ-037 Backpressure: out_ready low 10 cycles in DONE -> out_data stable, in_ready 0, result unchanged when released.
REQ-038 Reset mid-MAC at k=7 -> next cycle out_valid=0, in_ready=1; following impulse matches REQ-034 with cleared coefficients (all outputs 0).
REQ-039 coef_we during MAC with coef_data=+100 -> ignored; subsequent output uses prior coefficient.
